// File: rtl/display_pkg.sv
// Shared constants, scan-state type and digit-enable helper for the display scanner.
// SCAN_BLANK_EN adds the BLANK dead-time state between digits.
package display_pkg;

    localparam logic [7:0] LED_OFF    = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         NUM_DIGITS = 4;

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;
`else
    typedef enum logic [1:0] {IDLE, SHOW} scan_state_t;
`endif

    // Digit 0 is the rightmost digit and drives AN[0] low.
    function automatic logic [3:0] an_for_digit(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module slot_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with registered outputs.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES of dead time between digits.
//
// state | meaning
// IDLE  | all digits off, waiting for En
// SHOW  | one digit lit with its segment snapshot for SLOT_CYCLES
// BLANK | all digits off for BLANK_CYCLES before the next digit
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       En,
    input  logic [0:7] LED1,
    input  logic [0:7] LED2,
    input  logic [0:7] LED3,
    input  logic [0:7] LED4,
    output logic [0:7] SEG,
    output logic [3:0] AN,
    output logic [1:0] Digit,
    output logic       Frame
);

    localparam int MAX_CYC = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`endif

    scan_state_t state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [0:7]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_q, frame_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic [1:0]       show_digit;
    logic [0:7]       led_sel;
    logic             advance;
    logic             go_idle;

    slot_timer #(.W(CNT_W)) u_slot_timer (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    always_comb begin
        show_digit = (state_q == IDLE) ? 2'd0 : digit_q + 2'd1;
        case (show_digit)
            2'd0:    led_sel = LED4;
            2'd1:    led_sel = LED3;
            2'd2:    led_sel = LED2;
            default: led_sel = LED1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        seg_d    = seg_q;
        an_d     = an_q;
        frame_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = SLOT_LOAD;
        advance  = 1'b0;
        go_idle  = 1'b0;

        case (state_q)
            IDLE: begin
                if (En) begin
                    state_d  = SHOW;
                    digit_d  = 2'd0;
                    seg_d    = led_sel;
                    an_d     = an_for_digit(2'd0);
                    tmr_load = 1'b1;
                end
            end
            SHOW: begin
                if (!En) begin
                    go_idle = 1'b1;
                end else if (tmr_done) begin
`ifdef SCAN_BLANK_EN
                    state_d  = BLANK;
                    seg_d    = LED_OFF;
                    an_d     = AN_OFF;
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!En) begin
                    go_idle = 1'b1;
                end else if (tmr_done) begin
                    advance = 1'b1;
                end
            end
`endif
            default: go_idle = 1'b1;
        endcase

        if (advance) begin
            state_d  = SHOW;
            digit_d  = show_digit;
            seg_d    = led_sel;
            an_d     = an_for_digit(show_digit);
            frame_d  = (digit_q == 2'(NUM_DIGITS - 1));
            tmr_load = 1'b1;
            tmr_val  = SLOT_LOAD;
        end

        // Dropping En abandons the slot; the next IDLE->SHOW reloads the timer.
        if (go_idle) begin
            state_d = IDLE;
            digit_d = 2'd0;
            seg_d   = LED_OFF;
            an_d    = AN_OFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            digit_q <= 2'd0;
            seg_q   <= LED_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign Digit = digit_q;
    assign Frame = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a phase-position model predicts every output cycle.
module tb_display_scan_ctrl;

    localparam int S = 4;
`ifdef SCAN_BLANK_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int L = S + B;
    localparam int P = 4 * L;

    logic       CLK = 1'b0;
    logic       Reset, En;
    logic [0:7] LED1, LED2, LED3, LED4;
    logic [0:7] SEG;
    logic [3:0] AN;
    logic [1:0] Digit;
    logic       Frame;

    display_scan_ctrl #(.SLOT_CYCLES(S), .BLANK_CYCLES(1)) dut (
        .CLK(CLK), .Reset(Reset), .En(En),
        .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4),
        .SEG(SEG), .AN(AN), .Digit(Digit), .Frame(Frame)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] dig;
        logic       fr;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int obs_frames = 0;
    int exp_frames = 0;

    bit         m_act = 0;
    int         m_pos = 0;
    logic [7:0] m_seg = 8'hFF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [7:0] led_of(input int slot);
        case (slot)
            0:       return LED4;
            1:       return LED3;
            2:       return LED2;
            default: return LED1;
        endcase
    endfunction

    // Advance the model by one edge using the inputs as they will be sampled.
    task automatic step();
        exp_t e;
        bit   wrapped = 0;
        int   slot, off;
        if (Reset || !En) begin
            m_act = 0;
            m_pos = 0;
        end else if (!m_act) begin
            m_act = 1;
            m_pos = 0;
        end else if (m_pos == P - 1) begin
            m_pos = 0;
            wrapped = 1;
        end else begin
            m_pos++;
        end
        e.an = 4'b1111; e.seg = 8'hFF; e.dig = 2'd0; e.fr = 1'b0;
        if (m_act) begin
            slot = m_pos / L;
            off  = m_pos % L;
            if (off == 0) m_seg = led_of(slot);
            e.dig = 2'(slot);
            if (off < S) begin
                e.an  = ~(4'b0001 << slot);
                e.seg = m_seg;
            end
            e.fr = wrapped;
        end
        if (e.fr) exp_frames++;
        exp_q.push_back(e);

        @(posedge CLK);
        #1;
        cyc++;
        e = exp_q.pop_front();
        if (Frame === 1'b1) obs_frames++;
        chk("AN",    {28'b0, AN},    {28'b0, e.an});
        chk("SEG",   {24'b0, SEG},   {24'b0, e.seg});
        chk("Digit", {30'b0, Digit}, {30'b0, e.dig});
        chk("Frame", {31'b0, Frame}, {31'b0, e.fr});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model is at the requested slot/offset, bounded.
    task automatic run_until(input string tag, input int slot, input int off);
        int i = 0;
        while (!(m_act && (m_pos == slot * L + off)) && i < 3 * P) begin
            step();
            i++;
        end
        chk(tag, {31'b0, (m_act && (m_pos == slot * L + off))}, 32'd1);
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0;
        LED4 = 8'hC0; LED3 = 8'hF9; LED2 = 8'hA4; LED1 = 8'hB0;
        run(2);

        // Reset has priority over En.
        En = 1'b1;
        run(2);
        Reset = 1'b0; En = 1'b0;
        run(2);

        // Basic scan, with frame pulses across two periods.
        En = 1'b1;
        run(45);

        // Mid-slot change of LED4 must not disturb the held snapshot.
        run_until("reach_d0", 0, 1);
        LED4 = 8'h80;
        run(P + 2);

        // Drop En during digit 2, then restart without a frame.
        run_until("reach_d2", 2, 1);
        En = 1'b0;
        run(1);
        En = 1'b1;
        run(P + 3);

        // Reset pulse in the inter-digit gap (or late in a slot without blanking).
        run_until("reach_gap", 1, L - 1);
        Reset = 1'b1;
        run(1);
        Reset = 1'b0;
        run(6);

        // Random En drops and LED changes.
        for (int i = 0; i < 200; i++) begin
            En   = ($urandom_range(0, 15) != 0);
            LED1 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) LED4 = 8'($urandom);
            step();
        end
        En = 1'b1;
        run(2 * P);

        chk("frame_count", obs_frames, exp_frames);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 50000; clock cycles each digit is lit (min 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 8; dead-time cycles between digits (min 1; used only with SCAN_BLANK_EN).
REQ-003 SHALL have port CLK input 1; single system clock, rising edge.
REQ-004 SHALL have port Reset input 1; synchronous, active-high reset.
REQ-005 SHALL have port En input 1; scan enable.
REQ-006 SHALL have ports LED1, LED2, LED3, LED4 input 8 each, indexed [0:7]; active-low segment patterns (LED4 = rightmost digit).
REQ-007 SHALL have port SEG output 8, indexed [0:7]; shared active-low segment bus.
REQ-008 SHALL have port AN output 4; active-low digit enables, AN[0] = rightmost digit.
REQ-009 SHALL have port Digit output 2; index of the digit currently selected.
REQ-010 SHALL have port Frame output 1; one-cycle pulse per completed 4-digit scan.

Function
REQ-011 SHALL implement FSM states IDLE, SHOW, BLANK; all outputs registered.
REQ-012 IDLE: AN=4'b1111, SEG=8'hFF, Digit=0; En=1 at an edge SHALL enter SHOW for digit 0 at that edge.
REQ-013 Digit mapping SHALL be 0->LED4/AN=1110, 1->LED3/AN=1101, 2->LED2/AN=1011, 3->LED1/AN=0111.
REQ-014 On entry to SHOW, SEG SHALL load the selected LEDx; SEG holds that snapshot for the whole slot regardless of input changes.
REQ-015 SHOW SHALL last exactly SLOT_CYCLES cycles, counted by a down-counter loaded on entry.
REQ-016 At the end of SHOW, the FSM SHALL go to BLANK (macro defined) or directly to SHOW of the next digit (macro undefined).
REQ-017 BLANK SHALL drive AN=4'b1111, SEG=8'hFF for exactly BLANK_CYCLES cycles, then enter SHOW of the next digit.
REQ-018 Digit SHALL increment modulo 4 on each SHOW entry after the first; 3 wraps to 0.
REQ-019 Frame SHALL be 1 for exactly the first cycle of SHOW for digit 0 following digit 3; never on the first SHOW after IDLE.
REQ-020 En=0 sampled in SHOW or BLANK SHALL return the FSM to IDLE at that edge, with IDLE outputs; a partial slot is abandoned.
REQ-021 En held high SHALL give a period of 4*(SLOT_CYCLES+BLANK_CYCLES) cycles with the macro, or 4*SLOT_CYCLES without it.

Reset
REQ-022 Reset=1 at an edge SHALL force IDLE, AN=4'b1111, SEG=8'hFF, Digit=0, Frame=0, counter=0, with priority over En in every state.
REQ-023 Reset deasserted with En=1 SHALL start a scan at digit 0 on the next edge.

Configuration
REQ-024 Macro SCAN_BLANK_EN defined SHALL compile in the BLANK state and its counter (anti-ghosting dead time).
REQ-025 Macro SCAN_BLANK_EN undefined SHALL remove BLANK; BLANK_CYCLES is then ignored and digits switch back-to-back.

Structure
REQ-026 Package display_pkg SHALL hold LED_OFF=8'hFF, AN_OFF=4'b1111, NUM_DIGITS=4 and the scan-state enum type.
REQ-027 Sub-module slot_timer SHALL be a loadable down-counter (load, value, done) shared by SHOW and BLANK timing.

Verification (SLOT_CYCLES=4, BLANK_CYCLES=1)
REQ-028 LED4..LED1=8'hC0,8'hF9,8'hA4,8'hB0, En raised -> next edge AN=1110, SEG=C0 for 4 cycles, then AN=1111/SEG=FF for 1 cycle, then AN=1101, SEG=F9.
REQ-029 En held 45 cycles -> Frame pulses at cycles 21 and 41 after start, each 1 cycle wide; Digit sequence 0,1,2,3,0,...
REQ-030 LED4 changed mid-slot from C0 to 80 -> SEG stays C0 until slot end; the next digit-0 slot shows 80.
REQ-031 En dropped during digit-2 SHOW -> next edge AN=1111, SEG=FF, Digit=0; re-raised -> digit 0 restarts, no Frame.
REQ-032 Reset pulsed during BLANK with En=1 -> outputs at reset values that cycle; after release, AN=1110 next edge.
REQ-033 Macro undefined -> AN goes 1110 to 1101 with no 1111 cycle; scan period 16 cycles.
